// File: rtl/uart_rx_periph_pkg.sv
// Shared definitions for the UART receiver peripheral: register map, CON bit layout and
// receiver FSM state encoding.
package uart_rx_periph_pkg;

    localparam logic [31:0] RXD_ADDR_DEFAULT = 32'h4000_001C;
    localparam logic [31:0] CON_ADDR_DEFAULT = 32'h4000_0020;

    localparam int unsigned CON_IRQ_EN_BIT    = 1;
    localparam int unsigned CON_RX_VALID_BIT  = 3;
    localparam int unsigned CON_OVERRUN_BIT   = 4;
    localparam int unsigned CON_FRAME_ERR_BIT = 5;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

    // Oversampling divider for 16x sampling of one bit period.
    function automatic int unsigned ovs_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / (baud * 16);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial deserialiser: input synchroniser, 16x oversample tick, frame FSM and shift register.
// Emits the assembled byte with a one-cycle done pulse, or a one-cycle ferr pulse on a bad stop bit.
module uart_rx_core
    import uart_rx_periph_pkg::*;
#(
    parameter int unsigned OVS_DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       done_o,
    output logic       ferr_o
);

    localparam int unsigned CntW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [CntW-1:0] OvsLast = CntW'(OVS_DIV - 1);

    logic            rx_meta_q, rx_s_q;
    logic [CntW-1:0] ovs_cnt_q, ovs_cnt_d;
    logic [3:0]      tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q, shreg_d;
    rx_state_e       state_q, state_d;
    logic            tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            ovs_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            state_q    <= StIdle;
        end else begin
            rx_meta_q  <= rx_i;
            rx_s_q     <= rx_meta_q;
            ovs_cnt_q  <= ovs_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            state_q    <= state_d;
        end
    end

    assign tick = (ovs_cnt_q == OvsLast);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ovs_cnt_d  = tick ? '0 : ovs_cnt_q + 1'b1;
        done_o     = 1'b0;
        ferr_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    // Restart the tick phase so the mid-bit sample aligns with the falling edge.
                    state_d    = StStart;
                    tick_cnt_d = '0;
                    ovs_cnt_d  = '0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        if (!rx_s_q) begin
                            state_d   = StData;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        shreg_d    = {rx_s_q, shreg_q[7:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        done_o     = rx_s_q;
                        ferr_o     = !rx_s_q;
                        tick_cnt_d = '0;
                        state_d    = StIdle;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_byte_o = shreg_q;

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped UART receiver: self-decoded RXD/CON registers on the MEM-stage data bus,
// one-byte receive buffer with overrun/framing status and a level interrupt.
module uart_rx_periph
    import uart_rx_periph_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter logic [31:0] RXD_ADDR = RXD_ADDR_DEFAULT,
    parameter logic [31:0] CON_ADDR = CON_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_i,
    input  logic [31:0] addr_i,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int unsigned OVS_DIV = ovs_div(CLK_FREQ, BAUD);

    logic [7:0] rx_byte;
    logic       done, ferr;
    logic       rxd_sel, con_sel, rxd_rd, con_wr;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       frame_err_q, frame_err_d;
    logic       irq_en_q, irq_en_d;
    logic [31:0] con_val;
    logic       unused_wdata;

    uart_rx_core #(
        .OVS_DIV (OVS_DIV)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .rx_byte_o (rx_byte),
        .done_o    (done),
        .ferr_o    (ferr)
    );

    assign rxd_sel = (addr_i == RXD_ADDR);
    assign con_sel = (addr_i == CON_ADDR);
    assign rxd_rd  = rd_en_i && rxd_sel;
    assign con_wr  = wr_en_i && con_sel;

    assign unused_wdata = ^{wdata_i[31:6], wdata_i[3:2], wdata_i[0]};

    // Hardware set/load takes priority over CPU clear in the same cycle.
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        irq_en_d    = irq_en_q;

        if (rxd_rd) begin
            rx_valid_d = 1'b0;
        end
        if (con_wr) begin
            irq_en_d = wdata_i[CON_IRQ_EN_BIT];
            if (wdata_i[CON_OVERRUN_BIT]) begin
                overrun_d = 1'b0;
            end
            if (wdata_i[CON_FRAME_ERR_BIT]) begin
                frame_err_d = 1'b0;
            end
        end
        if (done) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q;
        end
        if (ferr) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_en_q    <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_en_q    <= irq_en_d;
        end
    end

    always_comb begin
        con_val                    = '0;
        con_val[CON_IRQ_EN_BIT]    = irq_en_q;
        con_val[CON_RX_VALID_BIT]  = rx_valid_q;
        con_val[CON_OVERRUN_BIT]   = overrun_q;
        con_val[CON_FRAME_ERR_BIT] = frame_err_q;
    end

    always_comb begin
        rdata_o = '0;
        if (rd_en_i && rxd_sel) begin
            rdata_o = {24'b0, rx_data_q};
        end else if (rd_en_i && con_sel) begin
            rdata_o = con_val;
        end
    end

    assign irq_o = rx_valid_q && irq_en_q;

endmodule

// File: tb/tb_uart_rx_periph.sv
// Directed bench for uart_rx_periph: 8N1 frames at 160 clk/bit, register reads/writes, error cases.
module tb_uart_rx_periph;

    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;
    localparam int BitClk = 160;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [31:0] rd_val;
    logic [31:0] early_con;
    logic        early_irq;

    uart_rx_periph #(
        .CLK_FREQ (1_600_000),
        .BAUD     (10_000),
        .RXD_ADDR (RXD),
        .CON_ADDR (CON)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_i    (rx),
        .addr_i  (addr),
        .rd_en_i (rd_en),
        .wr_en_i (wr_en),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr  = a;
        rd_en = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        rd_en = 1'b0;
        addr  = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame for stop_at clocks; peeks CON and irq at clock 1510 (before the stop sample).
    // A bad stop bit is held low only through its mid-bit sample so the line idles high afterwards.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int stop_at,
                              output logic [31:0] e_con, output logic e_irq);
        int idx;
        e_con = '0;
        e_irq = 1'b0;
        for (int c = 0; c < stop_at; c++) begin
            @(negedge clk);
            idx   = c / BitClk;
            rd_en = 1'b0;
            addr  = '0;
            if (idx == 0) rx = 1'b0;
            else if (idx <= 8) rx = d[idx-1];
            else rx = stop_ok ? 1'b1 : (c >= 1540);
            if (c == 1510) begin
                addr  = CON;
                rd_en = 1'b1;
                #1;
                e_con = rdata;
                e_irq = irq;
            end
        end
        @(negedge clk);
        rx    = 1'b1;
        rd_en = 1'b0;
        addr  = '0;
    endtask

    initial begin
        // Reset state
        idle(3);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        #1 rst_n = 1'b1;
        idle(2);
        bus_read(CON, rd_val); chk("rst_con", rd_val, 32'h0);
        bus_read(RXD, rd_val); chk("rst_rxd", rd_val, 32'h0);

        // 0xA5: valid appears only at the stop-bit sample point
        send_frame(8'hA5, 1'b1, 10 * BitClk, early_con, early_irq);
        chk("a5_early_con", early_con, 32'h0);
        bus_read(CON, rd_val); chk("a5_con", rd_val, 32'h08);
        chk("a5_irq_masked", {31'b0, irq}, 32'h0);
        bus_read(RXD, rd_val); chk("a5_rxd", rd_val, 32'h0000_00A5);
        bus_read(CON, rd_val); chk("a5_con_after", rd_val, 32'h0);

        // Interrupt enable, 0x3C
        bus_write(CON, 32'h2);
        bus_read(CON, rd_val); chk("irqen_con", rd_val, 32'h02);
        idle(20);
        send_frame(8'h3C, 1'b1, 10 * BitClk, early_con, early_irq);
        chk("3c_early_irq", {31'b0, early_irq}, 32'h0);
        chk("3c_irq", {31'b0, irq}, 32'h1);
        bus_read(32'h4000_0024, rd_val); chk("unmapped_rd", rd_val, 32'h0);
        bus_write(RXD, 32'hFF);
        bus_read(CON, rd_val); chk("3c_con", rd_val, 32'h0A);
        bus_read(RXD, rd_val); chk("3c_rxd", rd_val, 32'h0000_003C);
        chk("3c_irq_clr", {31'b0, irq}, 32'h0);

        // Overrun: 0x11 then 0x22 unread
        bus_write(CON, 32'h0);
        idle(20);
        send_frame(8'h11, 1'b1, 10 * BitClk, early_con, early_irq);
        idle(20);
        send_frame(8'h22, 1'b1, 10 * BitClk, early_con, early_irq);
        bus_read(CON, rd_val); chk("ovr_con", rd_val, 32'h18);
        bus_write(CON, 32'h10);
        bus_read(CON, rd_val); chk("ovr_clr_con", rd_val, 32'h08);
        bus_read(RXD, rd_val); chk("ovr_rxd", rd_val, 32'h0000_0022);
        bus_read(CON, rd_val); chk("ovr_con_after", rd_val, 32'h0);

        // Framing error: byte dropped, rx_data kept
        idle(20);
        send_frame(8'h55, 1'b0, 10 * BitClk, early_con, early_irq);
        idle(200);
        bus_read(CON, rd_val); chk("ferr_con", rd_val, 32'h20);
        bus_read(RXD, rd_val); chk("ferr_rxd_kept", rd_val, 32'h0000_0022);
        bus_write(CON, 32'h20);
        bus_read(CON, rd_val); chk("ferr_clr_con", rd_val, 32'h0);

        // Short low glitch is rejected at the start-bit midpoint
        @(negedge clk);
        rx = 1'b0;
        idle(40);
        rx = 1'b1;
        idle(200);
        bus_read(CON, rd_val); chk("glitch_con", rd_val, 32'h0);
        send_frame(8'h7E, 1'b1, 10 * BitClk, early_con, early_irq);
        bus_read(RXD, rd_val); chk("7e_rxd", rd_val, 32'h0000_007E);
        bus_read(CON, rd_val); chk("7e_con", rd_val, 32'h0);

        // Reset during bit 3 with state populated
        bus_write(CON, 32'h2);
        idle(20);
        send_frame(8'h99, 1'b1, 10 * BitClk, early_con, early_irq);
        chk("99_irq", {31'b0, irq}, 32'h1);
        idle(20);
        send_frame(8'hC3, 1'b1, 4 * BitClk + 80, early_con, early_irq);
        rst_n = 1'b0;
        idle(5);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        idle(5);
        bus_read(CON, rd_val); chk("mid_rst_con", rd_val, 32'h0);
        bus_read(RXD, rd_val); chk("mid_rst_rxd", rd_val, 32'h0);
        send_frame(8'hC3, 1'b1, 10 * BitClk, early_con, early_irq);
        bus_read(CON, rd_val); chk("c3_con", rd_val, 32'h08);
        bus_read(RXD, rd_val); chk("c3_rxd", rd_val, 32'h0000_00C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
